// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory read bus: single outstanding request with grant and response phases.
// IFU_BUS_ERROR_EN adds the im_err response qualifier.
interface instruction_fetch_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              im_req;
    logic [ADDR_W-1:0] im_addr;
    logic              im_gnt;
    logic              im_rvalid;
    logic [DATA_W-1:0] im_rdata;
`ifdef IFU_BUS_ERROR_EN
    logic              im_err;

    modport master (output im_req, im_addr, input im_gnt, im_rvalid, im_rdata, im_err);
    modport slave  (input im_req, im_addr, output im_gnt, im_rvalid, im_rdata, im_err);
`else
    modport master (output im_req, im_addr, input im_gnt, im_rvalid, im_rdata);
    modport slave  (input im_req, im_addr, output im_gnt, im_rvalid, im_rdata);
`endif
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: one outstanding instruction-memory read, results buffered with their PC in a FIFO.
// Optional bus-error reporting is enabled with `define IFU_BUS_ERROR_EN.
module instruction_fetch_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_W-1:0]     pc_addr,
    input  logic                  redirect,
    input  logic                  stall,
    output logic                  fetch_complete,
    instruction_fetch_unit_if.master im,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_W-1:0]     instr_data,
    output logic [ADDR_W-1:0]     instr_pc
`ifdef IFU_BUS_ERROR_EN
    ,
    output logic                  fetch_fault,
    output logic [ADDR_W-1:0]     fault_pc
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    state_t            state_q, state_d;
    logic              kill_q, kill_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;

    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem   [DEPTH];

    logic push;
    logic pop;
    logic resp_err;
    logic fault_pulse;

`ifdef IFU_BUS_ERROR_EN
    logic [ADDR_W-1:0] fault_pc_q, fault_pc_d;
    assign resp_err    = im.im_err;
    assign fetch_fault = fault_pulse;
    assign fault_pc    = fault_pc_q;
`else
    assign resp_err = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        kill_d         = kill_q;
        req_d          = req_q;
        addr_d         = addr_q;
        push           = 1'b0;
        fetch_complete = 1'b0;
        fault_pulse    = 1'b0;
`ifdef IFU_BUS_ERROR_EN
        fault_pc_d     = fault_pc_q;
`endif
        case (state_q)
            IDLE: begin
                if (!stall && !redirect && (count_q < FULL_CNT)) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    addr_d  = pc_addr;
                    kill_d  = 1'b0;
                end
            end
            REQ: begin
                // A redirect seen any time before the grant still kills the eventual response.
                kill_d = kill_q | redirect;
                if (im.im_gnt) begin
                    req_d   = 1'b0;
                    kill_d  = 1'b0;
                    state_d = (redirect || kill_q) ? DROP : WAIT;
                end
            end
            WAIT: begin
                if (im.im_rvalid) begin
                    state_d = IDLE;
                    if (!redirect) begin
                        if (resp_err) begin
                            fault_pulse = 1'b1;
`ifdef IFU_BUS_ERROR_EN
                            fault_pc_d  = addr_q;
`endif
                        end else begin
                            push           = 1'b1;
                            fetch_complete = 1'b1;
                        end
                    end
                end else if (redirect) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (im.im_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign instr_valid = (count_q != '0);
    assign pop         = instr_valid && instr_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (redirect) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            kill_q     <= 1'b0;
            req_q      <= 1'b0;
            addr_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
`ifdef IFU_BUS_ERROR_EN
            fault_pc_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            kill_q     <= kill_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
`ifdef IFU_BUS_ERROR_EN
            fault_pc_q <= fault_pc_d;
`endif
        end
    end

    // Storage needs no reset: the head outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= im.im_rdata;
            pc_mem[wr_ptr_q]   <= addr_q;
        end
    end

    assign instr_data = instr_valid ? data_mem[rd_ptr_q] : '0;
    assign instr_pc   = instr_valid ? pc_mem[rd_ptr_q]   : '0;
    assign im.im_req  = req_q;
    assign im.im_addr = addr_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed self-checking bench for instruction_fetch_unit: a per-cycle vector table
// followed by hand-written backpressure, redirect and error sequences.
module tb_instruction_fetch_unit;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] pc_addr = '0;
    logic        redirect = 1'b0;
    logic        stall = 1'b0;
    logic        fetch_complete;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
`ifdef IFU_BUS_ERROR_EN
    logic        fetch_fault;
    logic [31:0] fault_pc;
`endif

    int checks = 0;
    int failures = 0;

    instruction_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) im_if ();

    instruction_fetch_unit #(.ADDR_W(32), .DATA_W(32), .DEPTH(4)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .pc_addr        (pc_addr),
        .redirect       (redirect),
        .stall          (stall),
        .fetch_complete (fetch_complete),
        .im             (im_if.master),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc)
`ifdef IFU_BUS_ERROR_EN
        ,
        .fetch_fault    (fetch_fault),
        .fault_pc       (fault_pc)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        stall;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        ready;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_fc;
        logic        e_iv;
        logic [31:0] e_data;
        logic [31:0] e_ipc;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        redirect         = 1'b0;
        stall            = 1'b0;
        instr_ready      = 1'b0;
        im_if.im_gnt     = 1'b0;
        im_if.im_rvalid  = 1'b0;
        im_if.im_rdata   = '0;
`ifdef IFU_BUS_ERROR_EN
        im_if.im_err     = 1'b0;
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
    endtask

    task automatic wait_req(input logic [31:0] exp_addr);
        int n = 0;
        while (!im_if.im_req && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("req_seen", im_if.im_req, 1);
        chk("im_addr", im_if.im_addr, exp_addr);
    endtask

    task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] data);
        wait_req(exp_addr);
        im_if.im_gnt = 1'b1;
        @(negedge clk);
        im_if.im_gnt    = 1'b0;
        im_if.im_rvalid = 1'b1;
        im_if.im_rdata  = data;
        #1;
        chk("fetch_complete", fetch_complete, 1);
        @(negedge clk);
        im_if.im_rvalid = 1'b0;
        pc_addr = pc_addr + 1;
        $display("fetch addr=%0h data=%0h", exp_addr, data);
        #1;
    endtask

    initial begin
        vecs[0]  = '{32'h0, 0, 0, 0, 32'h0,        0, 0, 32'h0, 0, 0, 32'h0,        32'h0};
        vecs[1]  = '{32'h0, 0, 1, 0, 32'h0,        0, 1, 32'h0, 0, 0, 32'h0,        32'h0};
        vecs[2]  = '{32'h0, 0, 0, 1, 32'hDEADBEEF, 0, 0, 32'h0, 1, 0, 32'h0,        32'h0};
        vecs[3]  = '{32'h1, 0, 0, 0, 32'h0,        0, 0, 32'h0, 0, 1, 32'hDEADBEEF, 32'h0};
        vecs[4]  = '{32'h1, 0, 0, 0, 32'h0,        0, 1, 32'h1, 0, 1, 32'hDEADBEEF, 32'h0};
        vecs[5]  = '{32'h1, 0, 1, 0, 32'h0,        0, 1, 32'h1, 0, 1, 32'hDEADBEEF, 32'h0};
        vecs[6]  = '{32'h1, 0, 0, 0, 32'h0,        0, 0, 32'h1, 0, 1, 32'hDEADBEEF, 32'h0};
        vecs[7]  = '{32'h1, 0, 0, 1, 32'h11111111, 1, 0, 32'h1, 1, 1, 32'hDEADBEEF, 32'h0};
        vecs[8]  = '{32'h2, 0, 0, 0, 32'h0,        0, 0, 32'h1, 0, 1, 32'h11111111, 32'h1};
        vecs[9]  = '{32'h2, 1, 1, 0, 32'h0,        0, 1, 32'h2, 0, 1, 32'h11111111, 32'h1};
        vecs[10] = '{32'h2, 1, 0, 1, 32'h22222222, 1, 0, 32'h2, 1, 1, 32'h11111111, 32'h1};
        vecs[11] = '{32'h3, 1, 0, 0, 32'h0,        0, 0, 32'h2, 0, 1, 32'h22222222, 32'h2};
        vecs[12] = '{32'h3, 1, 0, 0, 32'h0,        1, 0, 32'h2, 0, 1, 32'h22222222, 32'h2};
        vecs[13] = '{32'h3, 0, 0, 0, 32'h0,        0, 0, 32'h2, 0, 0, 32'h0,        32'h0};
        vecs[14] = '{32'h3, 0, 1, 0, 32'h0,        0, 1, 32'h3, 0, 0, 32'h0,        32'h0};
        vecs[15] = '{32'h3, 0, 0, 1, 32'h33333333, 0, 0, 32'h3, 1, 0, 32'h0,        32'h0};
        vecs[16] = '{32'h4, 1, 0, 0, 32'h0,        1, 0, 32'h3, 0, 1, 32'h33333333, 32'h3};

        // Reset held while inputs toggle: every output stays at zero.
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            pc_addr         = 32'h100 + i;
            im_if.im_gnt    = i[0];
            im_if.im_rvalid = ~i[0];
            instr_ready     = 1'b1;
            #1;
            chk("rst_req", im_if.im_req, 0);
            chk("rst_addr", im_if.im_addr, 0);
            chk("rst_fc", fetch_complete, 0);
            chk("rst_iv", instr_valid, 0);
            chk("rst_data", instr_data, 0);
            chk("rst_ipc", instr_pc, 0);
            $display("reset cycle %0d req=%0b iv=%0b", i, im_if.im_req, instr_valid);
        end
        pc_addr = '0;
        do_reset();

        // Straight-line vectors, applied one per cycle starting in IDLE right after reset.
        for (int i = 0; i < 17; i++) begin
            pc_addr         = vecs[i].pc;
            stall           = vecs[i].stall;
            im_if.im_gnt    = vecs[i].gnt;
            im_if.im_rvalid = vecs[i].rv;
            im_if.im_rdata  = vecs[i].rdata;
            instr_ready     = vecs[i].ready;
            #1;
            chk("v_req", im_if.im_req, vecs[i].e_req);
            chk("v_addr", im_if.im_addr, vecs[i].e_addr);
            chk("v_fc", fetch_complete, vecs[i].e_fc);
            chk("v_iv", instr_valid, vecs[i].e_iv);
            chk("v_data", instr_data, vecs[i].e_data);
            chk("v_ipc", instr_pc, vecs[i].e_ipc);
            $display("vec %0d req=%0b addr=%0h fc=%0b iv=%0b data=%0h ipc=%0h", i,
                     im_if.im_req, im_if.im_addr, fetch_complete, instr_valid, instr_data, instr_pc);
            @(negedge clk);
        end

        // Backpressure: four pushes fill the FIFO, no fifth request until a pop.
        do_reset();
        pc_addr = 32'h0;
        for (int k = 0; k < 4; k++) fetch(k, 32'hA0 + k);
        for (int k = 0; k < 5; k++) begin
            chk("full_no_req", im_if.im_req, 0);
            @(negedge clk);
            #1;
        end
        chk("full_head_pc", instr_pc, 0);
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        #1;
        fetch(32'h4, 32'hA4);
        instr_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk("order_iv", instr_valid, 1);
            chk("order_pc", instr_pc, k);
            chk("order_data", instr_data, 32'hA0 + k);
            $display("pop pc=%0h data=%0h", instr_pc, instr_data);
            @(negedge clk);
            #1;
        end
        instr_ready = 1'b0;
        chk("drained_iv", instr_valid, 0);

        // Redirect during WAIT: late response is dropped, next fetch at the new PC.
        do_reset();
        pc_addr = 32'h10;
        wait_req(32'h10);
        im_if.im_gnt = 1'b1;
        @(negedge clk);
        im_if.im_gnt = 1'b0;
        redirect = 1'b1;
        pc_addr  = 32'h80;
        #1;
        chk("redir_wait_fc", fetch_complete, 0);
        @(negedge clk);
        redirect = 1'b0;
        #1;
        chk("drop_no_req", im_if.im_req, 0);
        @(negedge clk);
        im_if.im_rvalid = 1'b1;
        im_if.im_rdata  = 32'hBAD0BAD0;
        #1;
        chk("drop_fc", fetch_complete, 0);
        @(negedge clk);
        im_if.im_rvalid = 1'b0;
        #1;
        chk("drop_iv", instr_valid, 0);
        wait_req(32'h80);
        $display("redirect-in-wait next addr=%0h", im_if.im_addr);

        // Redirect during REQ before the grant: sticky kill sends the response to DROP.
        do_reset();
        pc_addr = 32'h30;
        wait_req(32'h30);
        redirect = 1'b1;
        pc_addr  = 32'h90;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        chk("kill_req_held", im_if.im_addr, 32'h30);
        im_if.im_gnt = 1'b1;
        @(negedge clk);
        im_if.im_gnt    = 1'b0;
        im_if.im_rvalid = 1'b1;
        #1;
        chk("kill_fc", fetch_complete, 0);
        @(negedge clk);
        im_if.im_rvalid = 1'b0;
        #1;
        chk("kill_iv", instr_valid, 0);
        wait_req(32'h90);
        $display("redirect-in-req next addr=%0h", im_if.im_addr);

        // Redirect, response and pop in the same cycle with two entries buffered.
        do_reset();
        pc_addr = 32'h0;
        fetch(32'h0, 32'hC0);
        fetch(32'h1, 32'hC1);
        wait_req(32'h2);
        im_if.im_gnt = 1'b1;
        @(negedge clk);
        im_if.im_gnt    = 1'b0;
        redirect        = 1'b1;
        im_if.im_rvalid = 1'b1;
        instr_ready     = 1'b1;
        pc_addr         = 32'h40;
        #1;
        chk("sim_fc", fetch_complete, 0);
        chk("sim_iv_before", instr_valid, 1);
        @(negedge clk);
        redirect        = 1'b0;
        im_if.im_rvalid = 1'b0;
        instr_ready     = 1'b0;
        #1;
        chk("sim_iv_after", instr_valid, 0);
        chk("sim_ipc_after", instr_pc, 0);
        wait_req(32'h40);
        $display("simultaneous redirect next addr=%0h", im_if.im_addr);

        // Asynchronous reset in the middle of a response.
        im_if.im_gnt = 1'b1;
        @(negedge clk);
        im_if.im_gnt    = 1'b0;
        im_if.im_rvalid = 1'b1;
        #1;
        chk("pre_arst_fc", fetch_complete, 1);
        reset_n = 1'b0;
        #1;
        chk("arst_fc", fetch_complete, 0);
        chk("arst_req", im_if.im_req, 0);
        chk("arst_addr", im_if.im_addr, 0);
        $display("async reset mid-response fc=%0b", fetch_complete);

`ifdef IFU_BUS_ERROR_EN
        // Error response: fault pulse and captured PC, then a clean retry at the same PC.
        do_reset();
        chk("fault_pc_rst", fault_pc, 0);
        pc_addr = 32'h20;
        wait_req(32'h20);
        im_if.im_gnt = 1'b1;
        @(negedge clk);
        im_if.im_gnt    = 1'b0;
        im_if.im_rvalid = 1'b1;
        im_if.im_err    = 1'b1;
        #1;
        chk("err_fault", fetch_fault, 1);
        chk("err_fc", fetch_complete, 0);
        @(negedge clk);
        im_if.im_rvalid = 1'b0;
        im_if.im_err    = 1'b0;
        #1;
        chk("err_fault_pulse", fetch_fault, 0);
        chk("err_fault_pc", fault_pc, 32'h20);
        chk("err_no_push", instr_valid, 0);
        fetch(32'h20, 32'hE0E0E0E0);
        chk("retry_iv", instr_valid, 1);
        chk("retry_pc", instr_pc, 32'h20);
        $display("bus error at %0h then retry data=%0h", fault_pc, instr_data);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch stage directly downstream of the program counter. Takes the current PC address, issues one instruction-memory read at a time over a request/grant/response handshake, and buffers returned words with their PC in a small FIFO for the decoder. Pulses `fetch_complete` back to the program counter when a word is accepted, so the PC advances. Drops in-flight and buffered words on a control-flow redirect.

## Interface
- `ADDR_W`, 32, PC and memory address width
- `DATA_W`, 32, instruction word width
- `DEPTH`, 4, instruction FIFO entries (power of 2, ≥2)
- `clk`  in  1  clock, all state on rising edge
- `reset_n`  in  1  asynchronous active-low reset
- `pc_addr`  in  ADDR_W  current PC (program counter `IM_ADDRESS_BUS`)
- `redirect`  in  1  PC discontinuity (jump/branch/call/return/interrupt/flush); kills fetch
- `stall`  in  1  inhibits starting new requests
- `fetch_complete`  out  1  one-cycle pulse: word accepted, PC may increment
- `im_req`  out  1  memory read request
- `im_addr`  out  ADDR_W  request address, stable while `im_req`
- `im_gnt`  in  1  request accepted this cycle
- `im_rvalid`  in  1  read data valid
- `im_rdata`  in  DATA_W  read data
- `instr_valid`  out  1  FIFO non-empty
- `instr_ready`  in  1  decoder accepts head
- `instr_data`  out  DATA_W  head word
- `instr_pc`  out  ADDR_W  head word's address

## Operation
- FSM states: IDLE, REQ, WAIT, DROP. At most one outstanding request.
- IDLE: if `!stall && !redirect && count < DEPTH` → latch `im_addr <= pc_addr`, go REQ. `im_rvalid` in IDLE ignored.
- REQ: `im_req=1`, held until `im_gnt`. On `im_gnt`: → WAIT, or → DROP if `redirect` seen this cycle or earlier in REQ (sticky kill flag). `im_addr` never changes in REQ.
- WAIT: on `im_rvalid && !redirect` → push {`im_addr`, `im_rdata`}, `fetch_complete=1`, → IDLE. On `redirect` without `im_rvalid` → DROP. On `redirect && im_rvalid` same cycle → discard, no pulse, → IDLE.
- DROP: wait for `im_rvalid`, discard data, no pulse, → IDLE.
- FIFO: head read combinationally from registered storage; pop on `instr_valid && instr_ready`. Pointers wrap modulo DEPTH; `count` is log2(DEPTH)+1 bits. Space is guaranteed for a push because requests start only when `count < DEPTH`.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- `redirect` empties the FIFO that cycle (count←0, pointers←0). Any pop or push in the same cycle is overridden.
- `stall` only gates IDLE→REQ. It does not cancel an active request or response.

## Timing
- Reset: state IDLE, FIFO empty, kill flag 0. `im_req`, `im_addr`, `fetch_complete`, `instr_valid`, `instr_data`, `instr_pc` all 0.
- `fetch_complete` is combinational from WAIT && `im_rvalid` && `!redirect`. The PC samples it on the same edge as the FIFO push.
- Best case per word: IDLE (1) + REQ with immediate `im_gnt` (1) + WAIT with `im_rvalid` next cycle (1) = 3 cycles. `instr_valid` rises the cycle after push.
- Memory response arrives ≥1 cycle after `im_gnt`.
- Reset asserted mid-transaction: everything returns to reset values immediately. The memory is required to be reset in the same domain.

## Configuration
- `IFU_BUS_ERROR_EN` defined: adds `im_err` (in, 1, qualifies `im_rvalid`), `fetch_fault` (out, 1), and `fault_pc` (out, ADDR_W).
  - Response with `im_err=1` in WAIT: not pushed, no `fetch_complete`, one-cycle `fetch_fault` pulse, `fault_pc <= im_addr` (held until next fault, reset 0), → IDLE.
  - Errors in DROP are ignored.
- Not defined: those ports are absent and every response is treated as good.

## Test plan
- Reset: hold `reset_n=0`, toggle inputs → all outputs 0, no `im_req`; release → `im_req` rises 2 cycles later with `im_addr=pc_addr`.
- Straight-line: `pc_addr=0x0`, `im_gnt` immediate, `im_rvalid` next cycle, data 0xDEADBEEF → single `fetch_complete` pulse; next cycle `instr_valid=1`, `instr_pc=0x0`, `instr_data=0xDEADBEEF`; next request at 0x1.
- Backpressure: `instr_ready=0`, PC 0..3 → exactly 4 pushes, no 5th `im_req`. One pop → count 3, next request at 0x4; head order 0,1,2,3 preserved across pointer wrap.
- Redirect in WAIT: after grant at 0x10, assert `redirect` with `pc_addr=0x80` → DROP. Late `im_rvalid` discarded, no pulse, FIFO empty; next `im_addr=0x80`.
- Simultaneous: `redirect`, `im_rvalid`, and pop in one cycle with 2 entries → count 0, no `fetch_complete`, `instr_valid=0` next cycle.
- With `IFU_BUS_ERROR_EN`: response at 0x20 with `im_err=1` → `fetch_fault` pulse, `fault_pc=0x20`, no push, no `fetch_complete`; a retry at the same PC completes normally.
